// File: rtl/lsu_access_sequencer_if.sv
// rtl/lsu_access_sequencer_if.sv - request/response bus between pipeline stage and lsu_access_sequencer
interface lsu_access_sequencer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic [2:0]            req_funct3_i;
   logic                  resp_valid_o;
   logic [DATA_WIDTH-1:0] resp_rdata_o;
   logic                  resp_err_o;

   // pipeline side: issues requests, receives responses
   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );

   // sequencer side
   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );
endinterface

// File: rtl/lsu_access_sequencer.sv
// rtl/lsu_access_sequencer.sv - load/store front-end for lsu; optional byte-beat splitting via MISALIGN_SPLIT_EN
module lsu_access_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset_n,
   lsu_access_sequencer_if.slave bus,
   output logic [ADDR_WIDTH-1:0] lsu_addr_o,
   output logic [DATA_WIDTH-1:0] lsu_wdata_o,
   output logic                  lsu_we_o,
   output logic [2:0]            lsu_dtype_o,
   input  logic [DATA_WIDTH-1:0] lsu_rdata_i
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   localparam logic [2:0] DT_BYTE   = 3'b000;
   localparam logic [2:0] DT_HALF   = 3'b001;
   localparam logic [2:0] DT_WORD   = 3'b010;
   localparam logic [2:0] DT_BYTE_U = 3'b011;
   localparam logic [2:0] DT_HALF_U = 3'b100;
   localparam logic [2:0] DT_NONE   = 3'b111;

   logic [1:0]            r_state;
   logic                  r_we;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [2:0]            r_dtype;

   logic [2:0]            w_dtype;
   logic                  w_legal;
   logic                  w_misal;
   logic                  w_reject;

`ifdef MISALIGN_SPLIT_EN
   logic                  r_split;
   logic [1:0]            r_beat;
   logic [1:0]            r_last_beat;
   logic                  r_half;
   logic                  r_signed;
   logic [DATA_WIDTH-1:0] r_bytes;
   logic                  w_last;
   logic [DATA_WIDTH-1:0] w_asm;
   logic [DATA_WIDTH-1:0] w_ext;

   // current beat's byte merged into the assembled word, then extended to the requested width
   always_comb begin
      w_last = !r_split || (r_beat == r_last_beat);
      w_asm  = r_bytes;
      w_asm[{r_beat, 3'b000} +: 8] = lsu_rdata_i[7:0];
      w_ext  = r_half ? {{16{r_signed & w_asm[15]}}, w_asm[15:0]} : w_asm;
   end
`endif

   // funct3 -> lsu dtype translation, legality and alignment of the offered request
   always_comb begin
      w_dtype = DT_NONE;
      w_legal = 1'b0;
      case (bus.req_funct3_i)
         3'b000:  begin w_dtype = DT_BYTE;   w_legal = 1'b1;           end
         3'b001:  begin w_dtype = DT_HALF;   w_legal = 1'b1;           end
         3'b010:  begin w_dtype = DT_WORD;   w_legal = 1'b1;           end
         3'b100:  begin w_dtype = DT_BYTE_U; w_legal = !bus.req_we_i;  end
         3'b101:  begin w_dtype = DT_HALF_U; w_legal = !bus.req_we_i;  end
         default: begin w_dtype = DT_NONE;   w_legal = 1'b0;           end
      endcase
      w_misal = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
                ((bus.req_funct3_i[1:0] == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
`ifdef MISALIGN_SPLIT_EN
      w_reject = !w_legal;
`else
      w_reject = !w_legal || w_misal;
`endif
   end

   // request capture and IDLE -> ISSUE -> CAPTURE -> RESP sequencing
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid_i) begin
                  r_we    <= bus.req_we_i;
                  r_addr  <= bus.req_addr_i;
                  r_wdata <= bus.req_wdata_i;
                  r_dtype <= w_dtype;
                  r_err   <= w_reject;
`ifdef MISALIGN_SPLIT_EN
                  r_split     <= w_misal;
                  r_beat      <= 2'd0;
                  r_last_beat <= (bus.req_funct3_i[1:0] == 2'b10) ? 2'd3 : 2'd1;
                  r_half      <= (bus.req_funct3_i[1:0] == 2'b01);
                  r_signed    <= !bus.req_funct3_i[2];
                  r_bytes     <= '0;
`endif
                  if (w_reject) begin
                     r_rdata <= '0;
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (r_we) begin
`ifdef MISALIGN_SPLIT_EN
                  if (w_last) begin
                     r_rdata <= '0;
                     r_state <= S_RESP;
                  end else begin
                     r_beat <= r_beat + 2'd1;
                  end
`else
                  r_rdata <= '0;
                  r_state <= S_RESP;
`endif
               end else begin
                  r_state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
`ifdef MISALIGN_SPLIT_EN
               if (r_split) begin
                  r_bytes <= w_asm;
                  if (w_last) r_rdata <= w_ext;
               end else begin
                  r_rdata <= lsu_rdata_i;
               end
               if (w_last) begin
                  r_state <= S_RESP;
               end else begin
                  r_beat  <= r_beat + 2'd1;
                  r_state <= S_ISSUE;
               end
`else
               r_rdata <= lsu_rdata_i;
               r_state <= S_RESP;
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // lsu drive: idle code 111 outside an access; gated by reset_n so a reset kills a write at once
   always_comb begin
      lsu_addr_o  = '0;
      lsu_wdata_o = '0;
      lsu_we_o    = 1'b0;
      lsu_dtype_o = DT_NONE;
      if (reset_n && ((r_state == S_ISSUE) || (r_state == S_CAPTURE))) begin
         lsu_addr_o  = r_addr;
         lsu_wdata_o = r_wdata;
         lsu_dtype_o = r_dtype;
         lsu_we_o    = r_we && (r_state == S_ISSUE);
`ifdef MISALIGN_SPLIT_EN
         lsu_addr_o = r_addr + ADDR_WIDTH'(r_beat);
         if (r_split) begin
            lsu_dtype_o = r_we ? DT_BYTE : DT_BYTE_U;
            lsu_wdata_o = DATA_WIDTH'(r_wdata[{r_beat, 3'b000} +: 8]);
         end
`endif
      end
   end

   assign bus.req_ready_o  = (r_state == S_IDLE);
   assign bus.resp_valid_o = reset_n && (r_state == S_RESP);
   assign bus.resp_err_o   = reset_n && (r_state == S_RESP) && r_err;
   assign bus.resp_rdata_o = r_rdata;

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// tb/tb_lsu_access_sequencer.sv - scoreboard bench for lsu_access_sequencer with a behavioural lsu
module tb_lsu_access_sequencer;
   localparam int DW = 32;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata;
   logic [DW-1:0] lsu_rdata;
   logic          lsu_we;
   logic [2:0]    lsu_dtype;

   lsu_access_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

   lsu_access_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (ifc),
      .lsu_addr_o  (lsu_addr),
      .lsu_wdata_o (lsu_wdata),
      .lsu_we_o    (lsu_we),
      .lsu_dtype_o (lsu_dtype),
      .lsu_rdata_i (lsu_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } exp_t;

   typedef struct {
      logic [11:0] addr;
      logic [7:0]  data;
   } wr_t;

   int          n_vec = 0;
   int          n_miss = 0;
   int          cyc = 0;
   int          we_cnt = 0;
   logic [7:0]  lsu_mem [4096];
   logic [7:0]  ref_mem [4096];
   exp_t        sb [$];
   wr_t         wr_log [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // behavioural lsu: combinational read with extension, byte-enabled write on posedge
   always_comb begin
      lsu_rdata = '0;
      case (lsu_dtype)
         3'b000: lsu_rdata = {{24{lsu_mem[lsu_addr][7]}}, lsu_mem[lsu_addr]};
         3'b011: lsu_rdata = {24'h0, lsu_mem[lsu_addr]};
         3'b001: lsu_rdata = {{16{lsu_mem[lsu_addr+12'd1][7]}}, lsu_mem[lsu_addr+12'd1], lsu_mem[lsu_addr]};
         3'b100: lsu_rdata = {16'h0, lsu_mem[lsu_addr+12'd1], lsu_mem[lsu_addr]};
         3'b010: lsu_rdata = {lsu_mem[lsu_addr+12'd3], lsu_mem[lsu_addr+12'd2],
                              lsu_mem[lsu_addr+12'd1], lsu_mem[lsu_addr]};
         default: lsu_rdata = '0;
      endcase
   end

   always @(posedge clk) begin
      if (lsu_we === 1'b1) begin
         wr_t w;
         we_cnt++;
         w.addr = lsu_addr;
         w.data = lsu_wdata[7:0];
         wr_log.push_back(w);
         case (lsu_dtype)
            3'b000, 3'b011: lsu_mem[lsu_addr] = lsu_wdata[7:0];
            3'b001, 3'b100: begin
               lsu_mem[lsu_addr]       = lsu_wdata[7:0];
               lsu_mem[lsu_addr+12'd1] = lsu_wdata[15:8];
            end
            3'b010: for (int i = 0; i < 4; i++) lsu_mem[lsu_addr+12'(i)] = lsu_wdata[i*8 +: 8];
            default: ;
         endcase
      end
   end

   // response monitor; a pulse seen just after edge k is counted as consumed at edge k+1
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      #1;
      if (ifc.resp_valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("resp_err", {31'h0, ifc.resp_err_o}, {31'h0, e.err});
            check("resp_rdata", ifc.resp_rdata_o, e.rdata);
            check("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   task automatic issue(input logic we, input logic [11:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input bit expect_resp, output int acc);
      exp_t        x;
      int          size;
      int          beats;
      int          t;
      bit          legal;
      bit          misal;
      bit          split_en;
      logic [31:0] v;
`ifdef MISALIGN_SPLIT_EN
      split_en = 1'b1;
`else
      split_en = 1'b0;
`endif
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                 : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misal = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
      x.err = !legal || (misal && !split_en);
      beats = misal ? size : 1;
      x.lat = x.err ? 1 : (we ? 1 + beats : 1 + 2 * beats);
      v = '0;
      if (!x.err && !we) begin
         for (int i = 0; i < size; i++) v[i*8 +: 8] = ref_mem[a + 12'(i)];
         if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
         if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      end
      x.rdata = v;
      if (!x.err && we && expect_resp)
         for (int i = 0; i < size; i++) ref_mem[a + 12'(i)] = d[i*8 +: 8];

      @(negedge clk);
      t = 0;
      while (ifc.req_ready_o !== 1'b1 && t < 30) begin
         @(negedge clk);
         t++;
      end
      if (ifc.req_ready_o !== 1'b1) begin
         check("ready_timeout", 32'd0, 32'd1);
         acc = -1;
         return;
      end
      ifc.req_valid_i  = 1'b1;
      ifc.req_we_i     = we;
      ifc.req_addr_i   = a;
      ifc.req_wdata_i  = d;
      ifc.req_funct3_i = f3;
      acc   = cyc + 1;
      x.acc = acc;
      if (expect_resp) sb.push_back(x);
      @(posedge clk);
      #1;
      ifc.req_valid_i = 1'b0;
      ifc.req_wdata_i = 32'hxxxx_xxxx;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         check("resp_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, a3, w0;
      for (int i = 0; i < 4096; i++) begin
         lsu_mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      ifc.req_valid_i  = 1'b0;
      ifc.req_we_i     = 1'b0;
      ifc.req_addr_i   = '0;
      ifc.req_wdata_i  = '0;
      ifc.req_funct3_i = '0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rst_ready", {31'h0, ifc.req_ready_o}, 32'd1);
      check("rst_resp_valid", {31'h0, ifc.resp_valid_o}, 32'd0);
      check("rst_resp_err", {31'h0, ifc.resp_err_o}, 32'd0);
      check("rst_resp_rdata", ifc.resp_rdata_o, 32'd0);
      check("rst_lsu_addr", {20'h0, lsu_addr}, 32'd0);
      check("rst_lsu_wdata", lsu_wdata, 32'd0);
      check("rst_lsu_we", {31'h0, lsu_we}, 32'd0);
      check("rst_lsu_dtype", {29'h0, lsu_dtype}, 32'd7);

      // reset while a store sits in ISSUE
      issue(1'b1, 12'h300, 32'hCAFEF00D, 3'b010, 1'b0, a1);
      check("mid_we_before_reset", {31'h0, lsu_we}, 32'd1);
      w0 = we_cnt;
      reset_n = 1'b0;
      #1;
      check("mid_reset_we", {31'h0, lsu_we}, 32'd0);
      check("mid_reset_dtype", {29'h0, lsu_dtype}, 32'd7);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_reset_ready", {31'h0, ifc.req_ready_o}, 32'd1);
      check("post_reset_dtype", {29'h0, lsu_dtype}, 32'd7);
      check("post_reset_no_write", 32'(we_cnt - w0), 32'd0);
      repeat (2) @(negedge clk);

      // aligned word round trip, and the aborted store never reached memory
      w0 = we_cnt;
      issue(1'b1, 12'h100, 32'hDEADBEEF, 3'b010, 1'b1, a1);
      drain();
      check("sw_we_pulses", 32'(we_cnt - w0), 32'd1);
      issue(1'b0, 12'h100, 32'h0, 3'b010, 1'b1, a1);
      issue(1'b0, 12'h300, 32'h0, 3'b010, 1'b1, a1);
      drain();

      // signed/unsigned half and byte loads
      issue(1'b1, 12'h202, 32'h00008001, 3'b001, 1'b1, a1);
      issue(1'b0, 12'h202, 32'h0, 3'b001, 1'b1, a1);
      issue(1'b0, 12'h202, 32'h0, 3'b101, 1'b1, a1);
      issue(1'b0, 12'h103, 32'h0, 3'b000, 1'b1, a1);
      issue(1'b0, 12'h103, 32'h0, 3'b100, 1'b1, a1);
      drain();

      // back-to-back store then load: one idle cycle after the store response
      issue(1'b1, 12'h010, 32'h0A0B0C0D, 3'b010, 1'b1, a1);
      issue(1'b0, 12'h010, 32'h0, 3'b010, 1'b1, a2);
      check("b2b_accept_gap", 32'(a2 - a1), 32'd3);
      drain();

`ifdef MISALIGN_SPLIT_EN
      // split word store across the top of the address space
      w0 = we_cnt;
      wr_log.delete();
      issue(1'b1, 12'hFFE, 32'h11223344, 3'b010, 1'b1, a1);
      drain();
      check("split_sw_pulses", 32'(we_cnt - w0), 32'd4);
      if (wr_log.size() == 4) begin
         check("split_w0_addr", {20'h0, wr_log[0].addr}, 32'h0FFE);
         check("split_w0_data", {24'h0, wr_log[0].data}, 32'h44);
         check("split_w1_addr", {20'h0, wr_log[1].addr}, 32'h0FFF);
         check("split_w1_data", {24'h0, wr_log[1].data}, 32'h33);
         check("split_w2_addr", {20'h0, wr_log[2].addr}, 32'h0000);
         check("split_w2_data", {24'h0, wr_log[2].data}, 32'h22);
         check("split_w3_addr", {20'h0, wr_log[3].addr}, 32'h0001);
         check("split_w3_data", {24'h0, wr_log[3].data}, 32'h11);
      end
      issue(1'b0, 12'hFFE, 32'h0, 3'b010, 1'b1, a1);
      issue(1'b0, 12'h101, 32'h0, 3'b001, 1'b1, a1);
      issue(1'b0, 12'h101, 32'h0, 3'b101, 1'b1, a1);
      drain();
`else
      // misaligned requests are rejected without touching lsu
      w0 = we_cnt;
      issue(1'b0, 12'h003, 32'h0, 3'b001, 1'b1, a1);
      issue(1'b1, 12'hFFE, 32'h11223344, 3'b010, 1'b1, a1);
      issue(1'b1, 12'h201, 32'h5555, 3'b001, 1'b1, a1);
      drain();
      check("misal_no_we", 32'(we_cnt - w0), 32'd0);
      issue(1'b0, 12'h200, 32'h0, 3'b010, 1'b1, a1);
      drain();
`endif

      // illegal funct3: error responses, no write, next request two cycles later
      w0 = we_cnt;
      issue(1'b1, 12'h100, 32'h00001234, 3'b100, 1'b1, a1);
      issue(1'b0, 12'h100, 32'h0, 3'b011, 1'b1, a2);
      check("err_accept_gap_1", 32'(a2 - a1), 32'd2);
      issue(1'b0, 12'h100, 32'h0, 3'b010, 1'b1, a3);
      check("err_accept_gap_2", 32'(a3 - a2), 32'd2);
      drain();
      check("illegal_no_we", 32'(we_cnt - w0), 32'd0);
      repeat (3) @(negedge clk);
      check("final_idle_dtype", {29'h0, lsu_dtype}, 32'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/lsu_access_sequencer.md
Name: lsu_access_sequencer

Overview:
- Request front-end between the execute/memory pipeline stage and lsu; drives lsu addr_in/data_in/WE_in/dtypes_in and consumes lsu data_out.
- Accepts one load/store per valid/ready handshake and translates RISC-V funct3 into lsu dtype codes.
- Issues the access and returns a single-cycle response with load data or an error.
- Splits misaligned half/word accesses into byte beats, because lsu only handles accesses within one aligned 32-bit row.

Parameters:
DATA_WIDTH, 32, data path width (only 32 supported)
ADDR_WIDTH, 12, byte address width; matches lsu address space of 4096

Ports:
clk  input  1  clock; all state on posedge
reset_n  input  1  reset, synchronous, active-low
req_valid_i  input  1  request present
req_ready_o  output  1  block can accept a request
req_we_i  input  1  1=store, 0=load
req_addr_i  input  ADDR_WIDTH  byte address
req_wdata_i  input  DATA_WIDTH  store data, right-aligned
req_funct3_i  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW)
resp_valid_o  output  1  one-cycle response pulse
resp_rdata_o  output  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err_o  output  1  illegal funct3 or unsupported misaligned access
lsu_addr_o  output  ADDR_WIDTH  to lsu addr_in
lsu_wdata_o  output  DATA_WIDTH  to lsu data_in
lsu_we_o  output  1  to lsu WE_in
lsu_dtype_o  output  3  to lsu dtypes_in
lsu_rdata_i  input  DATA_WIDTH  from lsu data_out

Behaviour:
- Reset values: state=IDLE; req_ready_o=1; resp_valid_o=0; resp_rdata_o=0; resp_err_o=0; lsu_addr_o=0; lsu_wdata_o=0; lsu_we_o=0; lsu_dtype_o=3'b111.
  - 3'b111 is lsu's "no bank enable" code and is driven whenever no access is active.
- Reset mid-operation: the request is discarded, no response, lsu_we_o drops in the same cycle the reset is sampled.
- funct3 to dtype mapping:
  - 000 -> 000 (BYTE); 001 -> 001 (HALF); 010 -> 010 (WORD); 100 -> 011 (BYTE_U); 101 -> 100 (HALF_U).
  - For stores, only 000/001/010 are legal.
  - Any other code -> error response, no lsu access.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Handshake: transfer occurs when req_valid_i && req_ready_o on a posedge. req_ready_o=1 only in IDLE. Request fields are registered at acceptance; inputs are don't-care afterwards.
- States:
  - IDLE: on transfer -> ISSUE if legal, else -> RESP with err=1.
  - ISSUE: drive lsu_addr_o = base+beat (mod 2^ADDR_WIDTH).
    - Aligned: dtype from the mapping; lsu_wdata_o = registered wdata.
    - Split beat: store uses dtype BYTE with lsu_wdata_o[7:0] = byte[beat]; load uses BYTE_U.
    - lsu_we_o=1 for stores, for exactly this cycle.
    - Store: last beat -> RESP, else beat++ and stay in ISSUE.
    - Load -> CAPTURE.
  - CAPTURE: address/dtype held; sample lsu_rdata_i.
    - Aligned: result = lsu_rdata_i.
    - Split: byte[beat] = lsu_rdata_i[7:0].
    - Last beat -> RESP, else beat++ -> ISSUE.
  - RESP: resp_valid_o=1 for one cycle.
    - Split loads: sign-extend (LH/LW) or zero-extend (LHU) the assembled little-endian bytes.
    - -> IDLE, req_ready_o=1 the next cycle.
- Beat count: 1 if aligned; 2 for split half; 4 for split word.
- Latency from acceptance edge to resp_valid_o:
  - Aligned store 2 cycles; aligned load 3.
  - Split store 1+N; split load 1+2N.
  - Error 1.
- Address wrap: beats past 0xFFF wrap to 0x000.
- resp_rdata_o holds its value after the pulse until the next response.
- Back-to-back requests: one idle cycle between responses minimum (RESP -> IDLE).

Optional Feature:
- Macro MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split into byte beats as above.
- Undefined:
  - Misaligned requests take IDLE -> RESP with resp_err_o=1 and resp_rdata_o=0.
  - No lsu access and no lsu_we_o pulse.
  - Beat counter and byte assembly logic are omitted.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles mid-store (in ISSUE) -> lsu_we_o=0 that cycle, resp_valid_o never pulses, req_ready_o=1, lsu_dtype_o=3'b111.
- Aligned word round trip: SW 0xDEADBEEF @0x100, then LW @0x100 -> store resp at +2 cycles with err=0; load resp at +3 cycles with rdata=0xDEADBEEF.
- Signed/unsigned half: SH 0x8001 @0x202, then LH @0x202 -> 0xFFFF8001; LHU @0x202 -> 0x00008001.
- Misaligned word with wrap (MISALIGN_SPLIT_EN): SW 0x11223344 @0xFFE -> four byte writes in order 0xFFE=44, 0xFFF=33, 0x000=22, 0x001=11. LW @0xFFE -> 0x11223344 at +9 cycles.
- Misaligned without MISALIGN_SPLIT_EN: LH @0x003 -> resp at +1 with err=1, rdata=0, lsu_we_o never asserted.
- Illegal funct3: store with funct3=100 -> err=1, no lsu_we_o pulse. Load with funct3=011 -> err=1. Next legal request is accepted 2 cycles after the error request's acceptance.
